// File: rtl/csr_access_ctrl_pkg.sv
// Shared types and constants for the machine CSR access sequencer.
package csr_access_ctrl_pkg;

  typedef enum logic [1:0] {
    CSR_FUNC_RW = 2'd0,
    CSR_FUNC_RS = 2'd1,
    CSR_FUNC_RC = 2'd2
  } csr_write_func;

  typedef enum logic {
    CSR_SEL_RS1  = 1'b0,
    CSR_SEL_UIMM = 1'b1
  } csr_input_sel;

  typedef struct packed {
    logic          read_enable;
    logic          write_enable;
    csr_input_sel  input_select;
    csr_write_func write_func;
  } csr_params;

  typedef enum logic [2:0] {
    CSR_ST_IDLE       = 3'd0,
    CSR_ST_READ       = 3'd1,
    CSR_ST_WRITE      = 3'd2,
    CSR_ST_RESP       = 3'd3,
    CSR_ST_TRAP_EPC   = 3'd4,
    CSR_ST_TRAP_CAUSE = 3'd5
`ifdef CSR_TRAP_TVAL_EN
    ,
    CSR_ST_TRAP_TVAL  = 3'd6
`endif
  } csr_ctrl_state;

  localparam logic [11:0] CSR_ADDR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_ADDR_MTVAL  = 12'h343;

  // Set/clear need the old value even when the instruction discards it.
  function automatic logic csr_needs_read(input csr_params p);
    return p.read_enable ||
           (p.write_func == CSR_FUNC_RS) ||
           (p.write_func == CSR_FUNC_RC);
  endfunction

endpackage

// File: rtl/csr_access_ctrl_rmw_alu.sv
// Combinational read-modify-write datapath for CSRRW/CSRRS/CSRRC.
module csr_rmw_alu
  import csr_access_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] old,
  input  logic [XLEN-1:0] operand,
  input  csr_write_func   write_func,
  output logic [XLEN-1:0] new_value
);

  // Select the new CSR value from the write function.
  always_comb begin
    new_value = operand;
    case (write_func)
      CSR_FUNC_RW: new_value = operand;
      CSR_FUNC_RS: new_value = old | operand;
      CSR_FUNC_RC: new_value = old & ~operand;
      default:     new_value = operand;
    endcase
  end

endmodule

// File: rtl/csr_access_ctrl.sv
// Sole master of the machine CSR file port: sequences CSR instructions as
// fixed-latency read-modify-write and writes mepc/mcause(/mtval) on trap entry.
// Optional feature macro: CSR_TRAP_TVAL_EN (adds the mtval write on traps).
module csr_access_ctrl
  import csr_access_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  csr_params             instr_params,
  input  logic [CSR_ADDR_W-1:0] instr_addr,
  input  logic [XLEN-1:0]       instr_rs1,
  input  logic [4:0]            instr_uimm,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic                  rsp_illegal,
  input  logic                  trap_valid,
  output logic                  trap_ready,
  input  logic [XLEN-1:0]       trap_pc,
  input  logic [XLEN-1:0]       trap_cause,
  input  logic [XLEN-1:0]       trap_tval,
  output logic                  trap_done,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic                  csr_rd_en,
  input  logic [XLEN-1:0]       csr_rdata,
  input  logic                  csr_rd_illegal,
  output logic                  csr_wr_en,
  output logic [XLEN-1:0]       csr_wdata
);

  csr_ctrl_state         state_q, state_d;
  csr_params             params_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]       rs1_q;
  logic [4:0]            uimm_q;
  logic [XLEN-1:0]       pc_q;
  logic [XLEN-1:0]       cause_q;
`ifdef CSR_TRAP_TVAL_EN
  logic [XLEN-1:0]       tval_q;
`else
  logic                  unused_tval;
  assign unused_tval = ^trap_tval;
`endif
  logic [XLEN-1:0]       old_q;
  logic                  illegal_q;
  logic                  trap_done_q;

  logic                  instr_fire;
  logic                  trap_fire;
  logic                  rd_issue;
  logic                  ro_violation;
  logic                  write_illegal;
  logic [XLEN-1:0]       operand;
  logic [XLEN-1:0]       new_value;
  logic                  last_trap_state;

  // Ready is forced low while reset is held, independent of the state register.
  assign trap_ready  = reset_n & (state_q == CSR_ST_IDLE);
  assign instr_ready = reset_n & (state_q == CSR_ST_IDLE) & ~trap_valid;
  assign trap_fire   = trap_valid & trap_ready;
  assign instr_fire  = instr_valid & instr_ready;

  assign rd_issue      = csr_needs_read(params_q);
  assign ro_violation  = params_q.write_enable && (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);
  assign write_illegal = illegal_q | ro_violation;
  assign operand       = (params_q.input_select == CSR_SEL_UIMM) ? XLEN'(uimm_q) : rs1_q;

`ifdef CSR_TRAP_TVAL_EN
  assign last_trap_state = (state_q == CSR_ST_TRAP_TVAL);
`else
  assign last_trap_state = (state_q == CSR_ST_TRAP_CAUSE);
`endif

  csr_rmw_alu #(
    .XLEN (XLEN)
  ) u_rmw_alu (
    .old        (old_q),
    .operand    (operand),
    .write_func (params_q.write_func),
    .new_value  (new_value)
  );

  // Next-state sequencing; trap has priority in IDLE, sequences never preempt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CSR_ST_IDLE: begin
        if (trap_fire) begin
          state_d = CSR_ST_TRAP_EPC;
        end else if (instr_fire) begin
          state_d = CSR_ST_READ;
        end
      end
      CSR_ST_READ:       state_d = CSR_ST_WRITE;
      CSR_ST_WRITE:      state_d = CSR_ST_RESP;
      CSR_ST_RESP:       state_d = CSR_ST_IDLE;
      CSR_ST_TRAP_EPC:   state_d = CSR_ST_TRAP_CAUSE;
`ifdef CSR_TRAP_TVAL_EN
      CSR_ST_TRAP_CAUSE: state_d = CSR_ST_TRAP_TVAL;
      CSR_ST_TRAP_TVAL:  state_d = CSR_ST_IDLE;
`else
      CSR_ST_TRAP_CAUSE: state_d = CSR_ST_IDLE;
`endif
      default:           state_d = CSR_ST_IDLE;
    endcase
  end

  // State register and the trap-completion pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CSR_ST_IDLE;
      trap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trap_done_q <= last_trap_state;
    end
  end

  // Capture request payloads at the accepting handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      params_q <= '0;
      addr_q   <= '0;
      rs1_q    <= '0;
      uimm_q   <= '0;
      pc_q     <= '0;
      cause_q  <= '0;
`ifdef CSR_TRAP_TVAL_EN
      tval_q   <= '0;
`endif
    end else begin
      if (instr_fire) begin
        params_q <= instr_params;
        addr_q   <= instr_addr;
        rs1_q    <= instr_rs1;
        uimm_q   <= instr_uimm;
      end
      if (trap_fire) begin
        pc_q    <= trap_pc;
        cause_q <= trap_cause;
`ifdef CSR_TRAP_TVAL_EN
        tval_q  <= trap_tval;
`endif
      end
    end
  end

  // Old value and illegal flag: sampled in READ, read-only check folded in WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state_q == CSR_ST_READ) begin
        old_q     <= rd_issue ? csr_rdata : '0;
        illegal_q <= rd_issue ? csr_rd_illegal : 1'b0;
      end else if (state_q == CSR_ST_WRITE) begin
        illegal_q <= write_illegal;
      end
    end
  end

  // Drive the CSR file port and response outputs from the current state.
  always_comb begin
    csr_addr    = '0;
    csr_rd_en   = 1'b0;
    csr_wr_en   = 1'b0;
    csr_wdata   = '0;
    rsp_valid   = 1'b0;
    rsp_rdata   = '0;
    rsp_illegal = 1'b0;
    case (state_q)
      CSR_ST_READ: begin
        csr_addr  = addr_q;
        csr_rd_en = rd_issue;
      end
      CSR_ST_WRITE: begin
        csr_addr  = addr_q;
        csr_wr_en = params_q.write_enable & ~write_illegal;
        csr_wdata = new_value;
      end
      CSR_ST_RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = illegal_q ? '0 : old_q;
        rsp_illegal = illegal_q;
      end
      CSR_ST_TRAP_EPC: begin
        csr_addr  = CSR_ADDR_W'(CSR_ADDR_MEPC);
        csr_wr_en = 1'b1;
        csr_wdata = pc_q & ~XLEN'(3);
      end
      CSR_ST_TRAP_CAUSE: begin
        csr_addr  = CSR_ADDR_W'(CSR_ADDR_MCAUSE);
        csr_wr_en = 1'b1;
        csr_wdata = cause_q;
      end
`ifdef CSR_TRAP_TVAL_EN
      CSR_ST_TRAP_TVAL: begin
        csr_addr  = CSR_ADDR_W'(CSR_ADDR_MTVAL);
        csr_wr_en = 1'b1;
        csr_wdata = tval_q;
      end
`endif
      default: ;
    endcase
  end

  assign trap_done = trap_done_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Scoreboard bench for csr_access_ctrl: stimulus pushes expected writes,
// responses and trap_done pulses; a monitor pops and compares them.
module tb_csr_access_ctrl;
  import csr_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  csr_params   instr_params;
  logic [11:0] instr_addr;
  logic [31:0] instr_rs1;
  logic [4:0]  instr_uimm;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic        trap_valid;
  logic        trap_ready;
  logic [31:0] trap_pc, trap_cause, trap_tval;
  logic        trap_done;
  logic [11:0] csr_addr;
  logic        csr_rd_en;
  logic [31:0] csr_rdata;
  logic        csr_rd_illegal;
  logic        csr_wr_en;
  logic [31:0] csr_wdata;

  csr_access_ctrl #(
    .XLEN       (32),
    .CSR_ADDR_W (12)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_params   (instr_params),
    .instr_addr     (instr_addr),
    .instr_rs1      (instr_rs1),
    .instr_uimm     (instr_uimm),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_illegal    (rsp_illegal),
    .trap_valid     (trap_valid),
    .trap_ready     (trap_ready),
    .trap_pc        (trap_pc),
    .trap_cause     (trap_cause),
    .trap_tval      (trap_tval),
    .trap_done      (trap_done),
    .csr_addr       (csr_addr),
    .csr_rd_en      (csr_rd_en),
    .csr_rdata      (csr_rdata),
    .csr_rd_illegal (csr_rd_illegal),
    .csr_wr_en      (csr_wr_en),
    .csr_wdata      (csr_wdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CSR file model: mstatus, mepc, mcause, mtval, mhartid (reads 5); others illegal.
  logic [31:0] m_mstatus = '0;
  logic [31:0] m_mepc    = '0;
  logic [31:0] m_mcause  = '0;
  logic [31:0] m_mtval   = '0;
  logic        pre_en    = 1'b0;
  logic [31:0] pre_val   = '0;

  always_comb begin
    csr_rdata      = '0;
    csr_rd_illegal = 1'b1;
    case (csr_addr)
      12'h300: begin csr_rdata = m_mstatus; csr_rd_illegal = 1'b0; end
      12'h341: begin csr_rdata = m_mepc;    csr_rd_illegal = 1'b0; end
      12'h342: begin csr_rdata = m_mcause;  csr_rd_illegal = 1'b0; end
      12'h343: begin csr_rdata = m_mtval;   csr_rd_illegal = 1'b0; end
      12'hF14: begin csr_rdata = 32'h5;     csr_rd_illegal = 1'b0; end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (pre_en) m_mstatus <= pre_val;
    else if (csr_wr_en && csr_addr == 12'h300) m_mstatus <= csr_wdata;
    if (csr_wr_en) begin
      case (csr_addr)
        12'h341: m_mepc   <= csr_wdata;
        12'h342: m_mcause <= csr_wdata;
        12'h343: m_mtval  <= csr_wdata;
        default: ;
      endcase
    end
  end

  typedef struct { logic [31:0] rdata; logic illegal; int unsigned due; } rsp_exp_t;
  typedef struct { logic [11:0] addr; logic [31:0] data; int unsigned due; } wr_exp_t;

  rsp_exp_t    rsp_q[$];
  wr_exp_t     wr_q[$];
  int unsigned done_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      chk("rd_wr_exclusive", {63'd0, csr_rd_en & csr_wr_en}, 64'd0);
      if (rsp_valid) begin
        chk("rsp_expected", {63'd0, rsp_q.size() > 0}, 64'd1);
        if (rsp_q.size() > 0) begin
          rsp_exp_t e;
          e = rsp_q.pop_front();
          chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
          chk("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e.illegal});
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (csr_wr_en) begin
        chk("wr_expected", {63'd0, wr_q.size() > 0}, 64'd1);
        if (wr_q.size() > 0) begin
          wr_exp_t w;
          w = wr_q.pop_front();
          chk("wr_addr", {52'd0, csr_addr}, {52'd0, w.addr});
          chk("wr_data", {32'd0, csr_wdata}, {32'd0, w.data});
          chk("wr_cycle", 64'(cyc), 64'(w.due));
        end
      end
      if (trap_done) begin
        chk("done_expected", {63'd0, done_q.size() > 0}, 64'd1);
        if (done_q.size() > 0) begin
          int unsigned d;
          d = done_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d));
        end
      end
    end
  end

  function automatic csr_params mk(input logic re, input logic we,
                                   input csr_input_sel sel, input csr_write_func f);
    csr_params p;
    p.read_enable  = re;
    p.write_enable = we;
    p.input_select = sel;
    p.write_func   = f;
    return p;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_instr_ready"}, {63'd0, instr_ready}, 64'd0);
    chk({tag, "_trap_ready"},  {63'd0, trap_ready},  64'd0);
    chk({tag, "_rsp_valid"},   {63'd0, rsp_valid},   64'd0);
    chk({tag, "_rsp_rdata"},   {32'd0, rsp_rdata},   64'd0);
    chk({tag, "_rsp_illegal"}, {63'd0, rsp_illegal}, 64'd0);
    chk({tag, "_trap_done"},   {63'd0, trap_done},   64'd0);
    chk({tag, "_csr_addr"},    {52'd0, csr_addr},    64'd0);
    chk({tag, "_csr_rd_en"},   {63'd0, csr_rd_en},   64'd0);
    chk({tag, "_csr_wr_en"},   {63'd0, csr_wr_en},   64'd0);
    chk({tag, "_csr_wdata"},   {32'd0, csr_wdata},   64'd0);
  endtask

  task automatic preload_mstatus(input logic [31:0] v);
    pre_val = v;
    pre_en  = 1'b1;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  // Present one CSR instruction, wait for acceptance, queue its expectations.
  task automatic do_instr(input csr_params p, input logic [11:0] a, input logic [31:0] r,
                          input logic [4:0] u, input logic [31:0] exp_rd, input logic exp_ill,
                          input logic exp_wr, input logic [31:0] exp_wd,
                          output int unsigned acc);
    bit found = 0;
    acc = 0;
    instr_params = p;
    instr_addr   = a;
    instr_rs1    = r;
    instr_uimm   = u;
    instr_valid  = 1'b1;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (instr_ready) begin
        found = 1;
        acc   = cyc;
      end
    end
    chk("instr_accept", {63'd0, found}, 64'd1);
    if (found) begin
      if (exp_wr) wr_q.push_back('{addr: a, data: exp_wd, due: acc + 2});
      rsp_q.push_back('{rdata: exp_rd, illegal: exp_ill, due: acc + 3});
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  int unsigned a1, a2, a3, a4, a5, tc, ic, rc;
  bit          hit;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset_n      = 1'b0;
    instr_valid  = 1'b0;
    instr_params = '0;
    instr_addr   = '0;
    instr_rs1    = '0;
    instr_uimm   = '0;
    trap_valid   = 1'b0;
    trap_pc      = '0;
    trap_cause   = '0;
    trap_tval    = '0;

    repeat (2) @(negedge clk);
    chk_quiet("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_instr_ready", {63'd0, instr_ready}, 64'd1);
    chk("post_reset_trap_ready",  {63'd0, trap_ready},  64'd1);
    @(posedge clk);
    #1;

    // CSRRS 0x300: 0x8 | 0x80 = 0x88, returns 0x8.
    preload_mstatus(32'h0000_0008);
    do_instr(mk(1, 1, CSR_SEL_RS1, CSR_FUNC_RS), 12'h300, 32'h0000_0080, 5'h00,
             32'h0000_0008, 1'b0, 1'b1, 32'h0000_0088, a1);

    // CSRRCI 0x300: 0xFFFFFFFF & ~0x1F = 0xFFFFFFE0; rs1 must be ignored.
    repeat (4) @(posedge clk);
    #1;
    preload_mstatus(32'hFFFF_FFFF);
    do_instr(mk(1, 1, CSR_SEL_UIMM, CSR_FUNC_RC), 12'h300, 32'h1234_5678, 5'h1F,
             32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFE0, a2);

    // CSRRW to read-only 0xF14 issued back to back: illegal, no write, rdata 0.
    do_instr(mk(1, 1, CSR_SEL_RS1, CSR_FUNC_RW), 12'hF14, 32'hCAFE_F00D, 5'h00,
             32'h0, 1'b1, 1'b0, 32'h0, a3);
    chk("b2b_accept_gap", 64'(a3 - a2), 64'd4);

    // CSRRS without write to nonexistent 0x7C0: illegal from the CSR file.
    do_instr(mk(1, 0, CSR_SEL_RS1, CSR_FUNC_RS), 12'h7C0, 32'h0, 5'h00,
             32'h0, 1'b1, 1'b0, 32'h0, a4);

    // CSRRW with rd=x0: no read issued, old reads back 0 despite mstatus=0xFFFFFFE0.
    do_instr(mk(0, 1, CSR_SEL_RS1, CSR_FUNC_RW), 12'h300, 32'h0000_1234, 5'h00,
             32'h0, 1'b0, 1'b1, 32'h0000_1234, a5);
    chk("b2b_gap_2", 64'(a5 - a4), 64'd4);

    // Trap and instruction requested together: trap wins.
    repeat (5) @(posedge clk);
    #1;
    trap_pc      = 32'h8000_0102;
    trap_cause   = 32'h0000_0002;
    trap_tval    = 32'hDEAD_BEEF;
    trap_valid   = 1'b1;
    instr_params = mk(1, 0, CSR_SEL_RS1, CSR_FUNC_RS);
    instr_addr   = 12'h341;
    instr_rs1    = '0;
    instr_uimm   = '0;
    instr_valid  = 1'b1;
    hit = 0;
    tc  = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      if (trap_ready) begin
        hit = 1;
        tc  = cyc;
        chk("instr_blocked_by_trap", {63'd0, instr_ready}, 64'd0);
      end
    end
    chk("trap_accept", {63'd0, hit}, 64'd1);
    wr_q.push_back('{addr: 12'h341, data: 32'h8000_0100, due: tc + 1});
    wr_q.push_back('{addr: 12'h342, data: 32'h0000_0002, due: tc + 2});
`ifdef CSR_TRAP_TVAL_EN
    wr_q.push_back('{addr: 12'h343, data: 32'hDEAD_BEEF, due: tc + 3});
    done_q.push_back(tc + 4);
`else
    done_q.push_back(tc + 3);
`endif
    @(posedge clk);
    #1 trap_valid = 1'b0;
    hit = 0;
    ic  = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      if (instr_ready) begin
        hit = 1;
        ic  = cyc;
      end
    end
    chk("instr_after_trap_accept", {63'd0, hit}, 64'd1);
`ifdef CSR_TRAP_TVAL_EN
    chk("instr_after_trap_cycle", 64'(ic - tc), 64'd4);
`else
    chk("instr_after_trap_cycle", 64'(ic - tc), 64'd3);
`endif
    rsp_q.push_back('{rdata: 32'h8000_0100, illegal: 1'b0, due: ic + 3});
    @(posedge clk);
    #1 instr_valid = 1'b0;

    // Reset pulsed in the WRITE cycle of a CSRRW: nothing may commit or respond.
    repeat (5) @(posedge clk);
    #1;
    instr_params = mk(1, 1, CSR_SEL_RS1, CSR_FUNC_RW);
    instr_addr   = 12'h300;
    instr_rs1    = 32'hA5A5_A5A5;
    instr_valid  = 1'b1;
    hit = 0;
    rc  = 0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(negedge clk);
      if (instr_ready) begin
        hit = 1;
        rc  = cyc;
      end
    end
    chk("reset_case_accept", {63'd0, hit}, 64'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk_quiet("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("release_instr_ready", {63'd0, instr_ready}, 64'd1);
    repeat (6) @(negedge clk);
    chk("mstatus_not_overwritten", {32'd0, m_mstatus}, {32'd0, 32'h0000_1234});
    chk("rsp_queue_drained",  64'(rsp_q.size()),  64'd0);
    chk("wr_queue_drained",   64'(wr_q.size()),   64'd0);
    chk("done_queue_drained", 64'(done_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
